// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
// Optional macro MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned CNT_W = 4;

  // Ops that occupy the unit for several cycles. The accumulate family is
  // only recognised when MDU_MADD_EN is defined; otherwise those codes
  // behave like OP_NONE.
  function automatic logic is_multicycle(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`else
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b0;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Divides use the longer latency; everything else multi-cycle is a multiply.
  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-stage request bus and HI/LO/status return for the MDU.
// Handshake: start is a single-cycle request qualifying op/a/b; there is no
// ready. The requester must not assert start while busy=1 (the D-stage stall
// guarantees this); such a request is dropped by the unit.
interface mdu_ctrl_if;
  import mdu_pkg::*;

  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  mdu_state_e  dbg_state;

  modport master (
    output start, op, a, b, d_is_md,
    input  busy, md_stall, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, a, b, d_is_md,
    output busy, md_stall, hi, lo, dbg_state
  );
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit result for multiply, divide and accumulate.
// wr_en is low when the result must not be committed (divide by zero).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        wr_en
);

  logic [63:0] sa, sb, prod_s, prod_u, acc;
  logic        b_nz;
  logic [31:0] b_safe, a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Signed divide is done on magnitudes so the most-negative / -1 case wraps
  // to 0x80000000 with remainder 0 and no tool-dependent overflow behaviour.
  always_comb begin
    sa     = {{32{a[31]}}, a};
    sb     = {{32{b[31]}}, b};
    prod_s = sa * sb;
    prod_u = {32'd0, a} * {32'd0, b};
    acc    = {hi, lo};
    b_nz   = (b != 32'd0);
    b_safe = b_nz ? b : 32'd1;
    a_mag  = a[31] ? (~a + 32'd1) : a;
    b_mag  = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    q_s    = (a[31] ^ b_safe[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = a[31] ? (~r_mag + 32'd1) : r_mag;
    q_u    = a / b_safe;
    r_u    = a % b_safe;
    result = 64'd0;
    wr_en  = 1'b0;
    case (op)
      OP_MULT:  begin result = prod_s;       wr_en = 1'b1; end
      OP_MULTU: begin result = prod_u;       wr_en = 1'b1; end
      OP_DIV:   begin result = {r_s, q_s};   wr_en = b_nz; end
      OP_DIVU:  begin result = {r_u, q_u};   wr_en = b_nz; end
      OP_MADD:  begin result = acc + prod_s; wr_en = 1'b1; end
      OP_MADDU: begin result = acc + prod_u; wr_en = 1'b1; end
      OP_MSUB:  begin result = acc - prod_s; wr_en = 1'b1; end
      OP_MSUBU: begin result = acc - prod_u; wr_en = 1'b1; end
      default:  begin result = 64'd0;        wr_en = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller owning HI/LO.
// The result is computed at the start edge and held in a pending register;
// a down-counter releases it into HI/LO after the fixed latency.
// Optional macro MDU_MADD_EN (see mdu_pkg) enables the accumulate ops.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             pend_wr_q, pend_wr_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;
  logic [63:0]      arith_res;
  logic             arith_wr;

  mdu_arith u_arith (
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (arith_res),
    .wr_en  (arith_wr)
  );

  // Next-state: accept work only in IDLE; count down in RUN and commit on 1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_multicycle(bus.op)) begin
            state_d   = ST_RUN;
            cnt_d     = is_div(bus.op) ? DIV_N : MULT_N;
            pend_d    = arith_res;
            pend_wr_d = arith_wr;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          state_d = ST_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  // The stall covers the start cycle too, so the D-stage MD op never
  // reaches EX while the new operation is being accepted.
  assign bus.md_stall  = bus.d_is_md & (busy_q | (bus.start & is_multicycle(bus.op)));
  assign bus.busy      = busy_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed tests for mdu_ctrl (MULT_CYCLES=5, DIV_CYCLES=10).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    bus.op    = OP_NONE;
  endtask

  // Counts cycles with busy=1, bounded so a stuck busy shows as a wrong count.
  task automatic run_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if (bus.md_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", bus.md_stall); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
    total++; if (bus.dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=0", bus.dbg_state); end
  endtask

  task automatic test_mult();
    int n;
    do_start(OP_MULT, 32'hFFFFFFFE, 32'd3);
    run_busy(n);
    total++; if (n != 5) begin bad++; $display("FAIL mult_busy got=%0d want=5", n); end
    total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", bus.hi); end
    total++; if (bus.lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo got=%h want=fffffffa", bus.lo); end
    do_start(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    run_busy(n);
    total++; if (n != 5) begin bad++; $display("FAIL multu_busy got=%0d want=5", n); end
    total++; if (bus.hi !== 32'h1) begin bad++; $display("FAIL multu_hi got=%h want=1", bus.hi); end
    total++; if (bus.lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_lo got=%h want=fffffffe", bus.lo); end
  endtask

  task automatic test_div();
    int n;
    do_start(OP_DIVU, 32'd100, 32'd7);
    run_busy(n);
    total++; if (n != 10) begin bad++; $display("FAIL divu_busy got=%0d want=10", n); end
    total++; if (bus.lo !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h want=e", bus.lo); end
    total++; if (bus.hi !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h want=2", bus.hi); end
    do_start(OP_DIV, 32'hFFFFFFF9, 32'd2);
    run_busy(n);
    total++; if (n != 10) begin bad++; $display("FAIL div_busy got=%0d want=10", n); end
    total++; if (bus.lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", bus.lo); end
    total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", bus.hi); end
    do_start(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    run_busy(n);
    total++; if (bus.lo !== 32'h80000000) begin bad++; $display("FAIL div_ovf_lo got=%h want=80000000", bus.lo); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL div_ovf_hi got=%h want=0", bus.hi); end
  endtask

  task automatic test_div_zero();
    int n;
    do_start(OP_MTHI, 32'h11, 32'h0);
    do_start(OP_MTLO, 32'h22, 32'h0);
    do_start(OP_DIV, 32'd5, 32'd0);
    run_busy(n);
    total++; if (n != 10) begin bad++; $display("FAIL divz_busy got=%0d want=10", n); end
    total++; if (bus.hi !== 32'h11) begin bad++; $display("FAIL divz_hi got=%h want=11", bus.hi); end
    total++; if (bus.lo !== 32'h22) begin bad++; $display("FAIL divz_lo got=%h want=22", bus.lo); end
    do_start(OP_DIVU, 32'd9, 32'd0);
    run_busy(n);
    total++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
      bad++; $display("FAIL divuz_hilo got=%h/%h want=11/22", bus.hi, bus.lo);
    end
  endtask

  task automatic test_stall();
    int n;
    bus.d_is_md = 1'b1;
    bus.start   = 1'b1;
    bus.op      = OP_MULT;
    bus.a       = 32'd3;
    bus.b       = 32'd4;
    #1;
    total++; if (bus.md_stall !== 1'b1) begin bad++; $display("FAIL stall_start got=%0b want=1", bus.md_stall); end
    tick();
    bus.start = 1'b0;
    bus.op    = OP_NONE;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      total++; if (bus.md_stall !== 1'b1) begin bad++; $display("FAIL stall_busy cyc=%0d got=%0b want=1", n, bus.md_stall); end
      // a second start in busy cycle 2 must be dropped
      if (n == 1) begin
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd100;
        bus.b     = 32'd100;
      end else begin
        bus.start = 1'b0;
        bus.op    = OP_NONE;
      end
      n++;
      tick();
    end
    bus.start = 1'b0;
    bus.op    = OP_NONE;
    total++; if (n != 5) begin bad++; $display("FAIL stall_busy_len got=%0d want=5", n); end
    total++; if (bus.md_stall !== 1'b0) begin bad++; $display("FAIL stall_drop got=%0b want=0", bus.md_stall); end
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'd12) begin
      bad++; $display("FAIL stall_ignore got=%h/%h want=0/c", bus.hi, bus.lo);
    end
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stall_no_rerun got=%0b want=0", bus.busy); end
    bus.d_is_md = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_start(OP_MTHI, 32'h55, 32'h0);
    do_start(OP_DIV, 32'd100, 32'd7);
    tick();
    tick();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_busy3 got=%0b want=1", bus.busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b want=0", bus.busy); end
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      bad++; $display("FAIL rmid_hilo got=%h/%h want=0/0", bus.hi, bus.lo);
    end
    for (int i = 0; i < 12; i++) tick();
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL rmid_late got=%h/%h busy=%0b want=0/0 busy=0", bus.hi, bus.lo, bus.busy);
    end
  endtask

  task automatic test_mthi();
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.a     = 32'hDEADBEEF;
    bus.d_is_md = 1'b1;
    #1;
    total++; if (bus.md_stall !== 1'b0) begin bad++; $display("FAIL mthi_stall got=%0b want=0", bus.md_stall); end
    tick();
    bus.start = 1'b0;
    bus.op    = OP_NONE;
    bus.d_is_md = 1'b0;
    total++; if (bus.hi !== 32'hDEADBEEF) begin bad++; $display("FAIL mthi_hi got=%h want=deadbeef", bus.hi); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%0b want=0", bus.busy); end
    do_start(OP_MTLO, 32'h1234, 32'h0);
    total++; if (bus.lo !== 32'h1234 || bus.hi !== 32'hDEADBEEF) begin
      bad++; $display("FAIL mtlo got=%h/%h want=deadbeef/1234", bus.hi, bus.lo);
    end
  endtask

  task automatic test_none();
    do_start(OP_NONE, 32'hAAAA, 32'h5);
    total++; if (bus.busy !== 1'b0 || bus.hi !== 32'hDEADBEEF || bus.lo !== 32'h1234) begin
      bad++; $display("FAIL none_op got=%h/%h busy=%0b want=deadbeef/1234 busy=0", bus.hi, bus.lo, bus.busy);
    end
    do_start(4'd11, 32'hAAAA, 32'h5);
    total++; if (bus.busy !== 1'b0 || bus.hi !== 32'hDEADBEEF || bus.lo !== 32'h1234) begin
      bad++; $display("FAIL undef_op got=%h/%h busy=%0b want=deadbeef/1234 busy=0", bus.hi, bus.lo, bus.busy);
    end
  endtask

  task automatic test_madd();
    int n;
    do_start(OP_MTHI, 32'h0, 32'h0);
    do_start(OP_MTLO, 32'd10, 32'h0);
    do_start(OP_MADD, 32'd2, 32'd3);
    run_busy(n);
`ifdef MDU_MADD_EN
    total++; if (n != 5) begin bad++; $display("FAIL madd_busy got=%0d want=5", n); end
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'd16) begin
      bad++; $display("FAIL madd got=%h/%h want=0/10", bus.hi, bus.lo);
    end
    do_start(OP_MSUB, 32'd2, 32'd10);
    run_busy(n);
    total++; if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFC) begin
      bad++; $display("FAIL msub got=%h/%h want=ffffffff/fffffffc", bus.hi, bus.lo);
    end
`else
    total++; if (n != 0) begin bad++; $display("FAIL madd_off_busy got=%0d want=0", n); end
    for (int i = 0; i < 6; i++) tick();
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'd10) begin
      bad++; $display("FAIL madd_off got=%h/%h want=0/a", bus.hi, bus.lo);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(OP_MULTU, 32'd7, 32'd6);
    run_busy(n);
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'd42) begin
      bad++; $display("FAIL b2b_first got=%h/%h want=0/2a", bus.hi, bus.lo);
    end
    do_start(OP_DIVU, 32'd42, 32'd5);
    run_busy(n);
    total++; if (n != 10) begin bad++; $display("FAIL b2b_busy got=%0d want=10", n); end
    total++; if (bus.hi !== 32'd2 || bus.lo !== 32'd8) begin
      bad++; $display("FAIL b2b_second got=%h/%h want=2/8", bus.hi, bus.lo);
    end
  endtask

  // scenario sequence and final report
  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = OP_NONE;
    bus.a       = 32'h0;
    bus.b       = 32'h0;
    bus.d_is_md = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall();
    test_reset_mid();
    test_mthi();
    test_none();
    test_madd();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
